// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V style load/store unit in front of a single-port word RAM
// Byte/halfword stores are done as read-modify-write of the containing word.
module load_store_unit #(
    parameter int LARGO = 1024
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     ram_write_enable,
    output logic                     ram_read_enable,
    output logic [$clog2(LARGO)-1:0] ram_addr,
    output logic [31:0]              ram_din,
    input  logic [31:0]              ram_dout
);

    localparam int AW = $clog2(LARGO);
    localparam logic [31:0] LARGO_W = 32'(LARGO);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_READ,
        WRITE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [31:0]     word_q;

    logic            accept;
    logic            misalign;
    logic            range_err;
    logic            f3_err;
    logic            req_err;

    assign accept = req_valid & req_ready;

    // Request legality is judged on the live inputs so the error path needs no extra cycle.
    always_comb begin
        misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        range_err = ({2'b00, req_addr[31:2]} >= LARGO_W);
        if (req_we)
            f3_err = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            f3_err = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
        req_err   = misalign || range_err || f3_err;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = DONE;
                    else if (!req_we)
                        state_nxt = READ;
                    else if (req_funct3 == 3'b010)
                        state_nxt = WRITE;
                    else
                        state_nxt = RMW_READ;
                end
            end
            READ:     state_nxt = DONE;
            RMW_READ: state_nxt = WRITE;
            WRITE:    state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            word_q  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state == READ || state == RMW_READ)
                word_q <= ram_dout;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] merged;

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = word_q[7:0];
            2'b01:   ld_byte = word_q[15:8];
            2'b10:   ld_byte = word_q[23:16];
            default: ld_byte = word_q[31:24];
        endcase
        ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];

        merged = word_q;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_err          = 1'b0;
        rsp_rdata        = 32'h0;
        ram_write_enable = 1'b0;
        ram_read_enable  = 1'b0;
        ram_din          = 32'h0;
        ram_addr         = addr_q[AW+1:2];
        case (state)
            IDLE:     req_ready = 1'b1;
            READ:     ram_read_enable = 1'b1;
            RMW_READ: ram_read_enable = 1'b1;
            WRITE: begin
                ram_write_enable = 1'b1;
                ram_din          = (f3_q[1:0] == 2'b10) ? wdata_q : merged;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!we_q && !err_q) begin
                    case (f3_q)
                        3'b000:  rsp_rdata = {{24{ld_byte[7]}}, ld_byte};
                        3'b100:  rsp_rdata = {24'h0, ld_byte};
                        3'b001:  rsp_rdata = {{16{ld_half[15]}}, ld_half};
                        3'b101:  rsp_rdata = {16'h0, ld_half};
                        3'b010:  rsp_rdata = word_q;
                        default: rsp_rdata = 32'h0;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table-driven bench for load_store_unit
// Includes a behavioural word RAM with asynchronous read and synchronous write.
module tb_load_store_unit;

    localparam int LARGO = 64;
    localparam int AW    = $clog2(LARGO);

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_write_enable;
    logic          ram_read_enable;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    load_store_unit #(.LARGO(LARGO)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_addr         (ram_addr),
        .ram_din          (ram_din),
        .ram_dout         (ram_dout)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:LARGO-1];
    int wr_total = 0;
    int w4_count = 0;
    int en_count = 0;
    int both_en  = 0;

    assign ram_dout = mem[ram_addr];

    always @(posedge CLK) begin
        if (ram_write_enable) begin
            mem[ram_addr] <= ram_din;
            wr_total      <= wr_total + 1;
            if (ram_addr == AW'(4))
                w4_count <= w4_count + 1;
        end
    end

    always @(negedge CLK) begin
        if (ram_read_enable || ram_write_enable)
            en_count <= en_count + 1;
        if (ram_read_enable && ram_write_enable)
            both_en <= both_en + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [25];

    task automatic do_req(input int idx, input vec_t v);
        int lat;
        int en0;
        int wr0;
        @(negedge CLK);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        check($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
        en0 = en_count;
        wr0 = wr_total;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d err", idx), 32'(rsp_err), 32'(v.err));
        check($sformatf("v%0d rdata", idx), rsp_rdata, v.rdata);
        if (v.err) begin
            check($sformatf("v%0d err ram enables", idx), 32'(en_count - en0), 32'd0);
            check($sformatf("v%0d err writes", idx), 32'(wr_total - wr0), 32'd0);
        end else begin
            check($sformatf("v%0d writes", idx), 32'(wr_total - wr0), v.we ? 32'd1 : 32'd0);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit seen_rsp;
        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 3'b010, 32'h80, 32'h11223344, 2, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 3'b000, 32'h81, 32'h000000AA, 3, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3'b010, 32'h80, 32'h0, 2, 1'b0, 32'h1122AA44};
        vecs[5]  = '{1'b1, 3'b010, 32'h20, 32'h0000F080, 2, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 3'b000, 32'h20, 32'h0, 2, 1'b0, 32'hFFFFFF80};
        vecs[7]  = '{1'b0, 3'b100, 32'h20, 32'h0, 2, 1'b0, 32'h00000080};
        vecs[8]  = '{1'b0, 3'b001, 32'h20, 32'h0, 2, 1'b0, 32'hFFFFF080};
        vecs[9]  = '{1'b0, 3'b101, 32'h20, 32'h0, 2, 1'b0, 32'h0000F080};
        vecs[10] = '{1'b0, 3'b010, 32'h02, 32'h0, 1, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 3'b001, 32'h03, 32'h12345678, 1, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 3'b010, 32'(4 * LARGO), 32'h0, 1, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 3'b001, 32'h22, 32'h12345678, 3, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 3'b010, 32'h20, 32'h0, 2, 1'b0, 32'h5678F080};
        vecs[15] = '{1'b0, 3'b000, 32'h23, 32'h0, 2, 1'b0, 32'h00000056};
        vecs[16] = '{1'b0, 3'b000, 32'h21, 32'h0, 2, 1'b0, 32'hFFFFFFF0};
        vecs[17] = '{1'b0, 3'b101, 32'h22, 32'h0, 2, 1'b0, 32'h00005678};
        vecs[18] = '{1'b0, 3'b011, 32'h00, 32'h0, 1, 1'b1, 32'h0};
        vecs[19] = '{1'b1, 3'b100, 32'h00, 32'h55, 1, 1'b1, 32'h0};
        vecs[20] = '{1'b1, 3'b000, 32'h83, 32'hFFFFFF55, 3, 1'b0, 32'h0};
        vecs[21] = '{1'b0, 3'b010, 32'h80, 32'h0, 2, 1'b0, 32'h5522AA44};
        vecs[22] = '{1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 2, 1'b0, 32'h0};
        vecs[23] = '{1'b0, 3'b001, 32'h42, 32'h0, 2, 1'b0, 32'hFFFFCAFE};
        vecs[24] = '{1'b0, 3'b100, 32'h40, 32'h0, 2, 1'b0, 32'h0000000D};

        RST_N      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset ram_we", 32'(ram_write_enable), 32'd0);
        check("reset ram_re", 32'(ram_read_enable), 32'd0);
        check("reset ram_addr", 32'(ram_addr), 32'h0);
        check("reset ram_din", ram_din, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 25; i++)
            do_req(i, vecs[i]);

        check("word4 write count", 32'(w4_count), 32'd1);
        check("word4 contents", mem[4], 32'hDEADBEEF);

        // Reset in the WRITE cycle of SB 0x40 must abandon the store.
        begin
            int wr0;
            wr0 = wr_total;
            @(negedge CLK);
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b000;
            req_addr   = 32'h40;
            req_wdata  = 32'h00000011;
            @(posedge CLK);
            #1;
            req_valid = 1'b0;
            @(posedge CLK);
            #1;
            check("rst-in-write ram_we before reset", 32'(ram_write_enable), 32'd1);
            RST_N = 1'b0;
            #1;
            check("rst-in-write ram_we during reset", 32'(ram_write_enable), 32'd0);
            check("rst-in-write ram_addr during reset", 32'(ram_addr), 32'h0);
            check("rst-in-write req_ready during reset", 32'(req_ready), 32'd1);
            @(posedge CLK);
            @(negedge CLK);
            RST_N = 1'b1;
            seen_rsp = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge CLK);
                if (rsp_valid)
                    seen_rsp = 1'b1;
            end
            check("rst-in-write no response", 32'(seen_rsp), 32'd0);
            check("rst-in-write writes", 32'(wr_total - wr0), 32'd0);
            check("rst-in-write word 0x40", mem[16], 32'hCAFEF00D);
            check("rst-in-write req_ready after", 32'(req_ready), 32'd1);
        end

        do_req(99, '{1'b0, 3'b010, 32'h40, 32'h0, 2, 1'b0, 32'hCAFEF00D});

        // req_valid held high: one accept every three cycles, ready only in IDLE.
        @(negedge CLK);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        for (int i = 0; i < 12; i++) begin
            if (i > 0)
                @(negedge CLK);
            check($sformatf("b2b c%0d ready", i), 32'(req_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b c%0d rsp_valid", i), 32'(rsp_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2)
                check($sformatf("b2b c%0d rdata", i), rsp_rdata, 32'hDEADBEEF);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);

        check("read/write enables exclusive", 32'(both_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
